approx_mult_err_monitor: RTL and testbench
==========================================

// Module: approx_mult_err_monitor
// PURPOSE
//   Streaming error-metric accumulator downstream of an unsigned WxW approximate multiplier.
//   Per sample, takes the operands x, y and the multiplier's approximate product z_approx.
//   Recomputes the exact product and accumulates error statistics over a run of N_SAMPLES.
//   Used in hardware characterisation of the approximate-multiplier library.
// PARAMETERS
//   W          8        operand width; products are 2*W bits
//   N_SAMPLES  65536    samples per run (>=1); 65536 = exhaustive 8x8 sweep
//   ACC_W      36       width of sum-of-error-distance accumulator
//   CNT_W      17       width of sample/error counters (must hold N_SAMPLES)
// PORTS
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   start      in   1        pulse: clear statistics and begin a run (honoured only in IDLE/DONE)
//   in_valid   in   1        sample present on x/y/z_approx
//   in_ready   out  1        block accepts sample this cycle
//   x          in   W        operand x
//   y          in   W        operand y
//   z_approx   in   2*W      approximate product of x*y
//   busy       out  1        run in progress (RUN or DRAIN)
//   done       out  1        level, high in DONE until next start
//   sum_ed     out  ACC_W    sum of |x*y - z_approx| over run
//   max_ed     out  2*W      maximum single error distance in run
//   err_cnt    out  CNT_W    number of samples with z_approx != x*y
//   smp_cnt    out  CNT_W    samples accepted so far in current run
// BEHAVIOUR
//   Reset: state=IDLE; in_ready, busy, done = 0; sum_ed, max_ed, err_cnt, smp_cnt = 0; pipe valids = 0.
//   FSM: IDLE -start-> RUN; RUN -(N_SAMPLES accepted)-> DRAIN; DRAIN -(pipe empty)-> DONE; DONE -start-> RUN.
//   start in IDLE/DONE: clears all statistics in the same edge that enters RUN; start ignored in RUN/DRAIN.
//   in_ready = 1 only in RUN and smp_cnt < N_SAMPLES; handshake = in_valid & in_ready.
//     The cycle the final sample is accepted, FSM goes to DRAIN and in_ready drops next cycle.
//   Pipeline, 2 stages, no backpressure inside:
//     S1 (accept edge): register x*y (exact, 2*W bits) and z_approx; smp_cnt += 1.
//     S2: ed = |exact - z_approx| (2*W bits, unsigned, no overflow);
//       sum_ed += ed; max_ed = max(max_ed, ed); err_cnt += (ed != 0).
//   Latency: a sample accepted at edge k is reflected in the statistics after edge k+2.
//   DRAIN lasts exactly 2 cycles; done asserts after the final sample updates the statistics.
//   sum_ed saturates at all-ones; it never wraps. max_ed and err_cnt cannot overflow by construction.
//   in_valid with in_ready=0: sample is not consumed and not counted; the source holds it.
//   Async reset mid-run: everything returns to reset values immediately and the run is lost.
//   Outputs are registered and stable in DONE until the next start.
// CONFIGURATION
//   APPROX_ERR_BIAS_EN defined: adds output err_bias (signed, ACC_W+1 bits).
//     err_bias = sum of (z_approx - exact), signed, saturating at both extremes.
//     Reset and start-clear it to 0; updated in S2 alongside sum_ed.
//   Not defined: port err_bias and its logic are absent; all other behaviour identical.
// TESTING
//   Exact source (z_approx = x*y), N=16, in_valid=1 throughout -> done after 16+2+1 cycles;
//     sum_ed = 0, max_ed = 0, err_cnt = 0, smp_cnt = 16.
//   N=4, samples (3,5,z=14),(255,255,z=65025),(0,7,z=1),(16,16,z=200)
//     -> sum_ed = 1+0+1+56 = 58, max_ed = 56, err_cnt = 3.
//     With APPROX_ERR_BIAS_EN: err_bias = -1+0+1-56 = -56.
//   Random in_valid gaps with N=8 -> in_ready falls after the 8th handshake;
//     smp_cnt = 8; extra valid samples not counted.
//   start pulsed during RUN -> ignored; start in DONE -> statistics cleared to 0 on the next edge, busy=1.
//   ACC_W=16, N=4, each sample x=y=255, z=0 (ed=65025) -> sum_ed saturates at 16'hFFFF, max_ed = 65025.
//   rst_n low mid-run after 5 samples -> all outputs 0, state IDLE; a new start runs normally from 0.

Source files
------------

// File: rtl/approx_mult_err_monitor.sv
// approx_mult_err_monitor
// Streaming error-metric accumulator placed after an unsigned WxW approximate
// multiplier. Recomputes the exact product per sample and accumulates the sum,
// maximum and count of error distances over a run of N_SAMPLES samples.
// Optional feature macro: APPROX_ERR_BIAS_EN adds a signed, saturating err_bias
// output (sum of z_approx - exact).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset, waiting for start
// S_RUN   | accepting samples until N_SAMPLES handshakes
// S_DRAIN | last sample accepted, pipeline still updating statistics
// S_DONE  | statistics final and stable until next start
module approx_mult_err_monitor #(
  parameter int W         = 8,
  parameter int N_SAMPLES = 65536,
  parameter int ACC_W     = 36,
  parameter int CNT_W     = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       x,
  input  logic [W-1:0]       y,
  input  logic [2*W-1:0]     z_approx,
  output logic               busy,
  output logic               done,
  output logic [ACC_W-1:0]   sum_ed,
  output logic [2*W-1:0]     max_ed,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W-1:0]   smp_cnt
`ifdef APPROX_ERR_BIAS_EN
  ,
  output logic signed [ACC_W:0] err_bias
`endif
);

  localparam logic [CNT_W-1:0] N_CNT  = CNT_W'(N_SAMPLES);
  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_SAMPLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic               clear;
  logic               accept;
  logic               v1, v2;
  logic [2*W-1:0]     exact1, za1;
  logic [2*W-1:0]     ed2;
  logic [ACC_W:0]     sum_wide;

  assign accept   = in_valid & in_ready;
  // One spare bit catches the carry so the sum can clamp instead of wrapping.
  assign sum_wide = {1'b0, sum_ed} + (ACC_W+1)'(ed2);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    clear     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy     = 1'b1;
        in_ready = (smp_cnt < N_CNT);
        if (in_valid && in_ready && smp_cnt == N_LAST) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        // Once stage 1 is empty, the edge that retires stage 2 is the last update.
        if (!v1) state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          clear     = 1'b1;
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage 1 captures the exact product; stage 2 forms the error distance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      exact1 <= '0;
      za1    <= '0;
      ed2    <= '0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      if (accept) begin
        exact1 <= (2*W)'(x) * (2*W)'(y);
        za1    <= z_approx;
      end
      if (v1) ed2 <= (exact1 >= za1) ? (exact1 - za1) : (za1 - exact1);
    end
  end

  // Run statistics, cleared by an honoured start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_ed  <= '0;
      max_ed  <= '0;
      err_cnt <= '0;
      smp_cnt <= '0;
    end else if (clear) begin
      sum_ed  <= '0;
      max_ed  <= '0;
      err_cnt <= '0;
      smp_cnt <= '0;
    end else begin
      if (accept) smp_cnt <= smp_cnt + CNT_W'(1);
      if (v2) begin
        sum_ed <= sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
        if (ed2 > max_ed) max_ed <= ed2;
        if (ed2 != '0)    err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

`ifdef APPROX_ERR_BIAS_EN
  logic signed [2*W:0]   diff2;
  logic signed [ACC_W+1:0] bias_wide;

  assign bias_wide = (ACC_W+2)'(err_bias) + (ACC_W+2)'(diff2);

  // Signed difference travels alongside ed2; the bias clamps at both extremes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff2    <= '0;
      err_bias <= '0;
    end else begin
      if (v1) diff2 <= $signed({1'b0, za1}) - $signed({1'b0, exact1});
      if (clear) begin
        err_bias <= '0;
      end else if (v2) begin
        if (bias_wide[ACC_W+1] != bias_wide[ACC_W])
          err_bias <= bias_wide[ACC_W+1] ? {1'b1, {ACC_W{1'b0}}} : {1'b0, {ACC_W{1'b1}}};
        else
          err_bias <= bias_wide[ACC_W:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Directed bench for approx_mult_err_monitor: four instances with different
// N_SAMPLES / ACC_W settings share one clock and reset.
// Index 0: N=16, 1: N=4, 2: N=8, 3: N=4 with ACC_W=16.
module tb_approx_mult_err_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st [4];
  logic        iv [4];
  logic [7:0]  xa [4];
  logic [7:0]  ya [4];
  logic [15:0] za [4];
  logic        ir [4];
  logic        bz [4];
  logic        dn [4];
  logic [35:0] sum [3];
  logic [15:0] sum_s;
  logic [15:0] mx [4];
  logic [16:0] ec [4];
  logic [16:0] sc [4];
`ifdef APPROX_ERR_BIAS_EN
  logic signed [36:0] eb [3];
  logic signed [16:0] eb_s;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  approx_mult_err_monitor #(.N_SAMPLES(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .x(xa[0]), .y(ya[0]), .z_approx(za[0]), .busy(bz[0]), .done(dn[0]),
    .sum_ed(sum[0]), .max_ed(mx[0]), .err_cnt(ec[0]), .smp_cnt(sc[0])
`ifdef APPROX_ERR_BIAS_EN
    , .err_bias(eb[0])
`endif
  );

  approx_mult_err_monitor #(.N_SAMPLES(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .x(xa[1]), .y(ya[1]), .z_approx(za[1]), .busy(bz[1]), .done(dn[1]),
    .sum_ed(sum[1]), .max_ed(mx[1]), .err_cnt(ec[1]), .smp_cnt(sc[1])
`ifdef APPROX_ERR_BIAS_EN
    , .err_bias(eb[1])
`endif
  );

  approx_mult_err_monitor #(.N_SAMPLES(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .x(xa[2]), .y(ya[2]), .z_approx(za[2]), .busy(bz[2]), .done(dn[2]),
    .sum_ed(sum[2]), .max_ed(mx[2]), .err_cnt(ec[2]), .smp_cnt(sc[2])
`ifdef APPROX_ERR_BIAS_EN
    , .err_bias(eb[2])
`endif
  );

  approx_mult_err_monitor #(.N_SAMPLES(4), .ACC_W(16)) usat (
    .clk(clk), .rst_n(rst_n), .start(st[3]), .in_valid(iv[3]), .in_ready(ir[3]),
    .x(xa[3]), .y(ya[3]), .z_approx(za[3]), .busy(bz[3]), .done(dn[3]),
    .sum_ed(sum_s), .max_ed(mx[3]), .err_cnt(ec[3]), .smp_cnt(sc[3])
`ifdef APPROX_ERR_BIAS_EN
    , .err_bias(eb_s)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int i, input logic v, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] z);
    iv[i] = v; xa[i] = a; ya[i] = b; za[i] = z;
  endtask

  task automatic pulse_start(input int i);
    st[i] = 1'b1;
    tick;
    st[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int lim);
    int n = 0;
    while (!dn[i] && n < lim) begin
      tick;
      n++;
    end
    total++;
    if (dn[i] !== 1'b1) begin bad++; $display("FAIL wait_done[%0d] done=%b after %0d cycles, need 1", i, dn[i], n); end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 4; i++) begin
      total++; if (ir[i] !== 1'b0) begin bad++; $display("FAIL rst_in_ready[%0d] got %b need 0", i, ir[i]); end
      total++; if (bz[i] !== 1'b0) begin bad++; $display("FAIL rst_busy[%0d] got %b need 0", i, bz[i]); end
      total++; if (dn[i] !== 1'b0) begin bad++; $display("FAIL rst_done[%0d] got %b need 0", i, dn[i]); end
      total++; if (mx[i] !== 16'd0) begin bad++; $display("FAIL rst_max[%0d] got %0d need 0", i, mx[i]); end
      total++; if (ec[i] !== 17'd0) begin bad++; $display("FAIL rst_err[%0d] got %0d need 0", i, ec[i]); end
      total++; if (sc[i] !== 17'd0) begin bad++; $display("FAIL rst_smp[%0d] got %0d need 0", i, sc[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      total++; if (sum[i] !== 36'd0) begin bad++; $display("FAIL rst_sum[%0d] got %0d need 0", i, sum[i]); end
    end
    total++; if (sum_s !== 16'd0) begin bad++; $display("FAIL rst_sum_sat got %0d need 0", sum_s); end
  endtask

  task automatic test_exact;
    pulse_start(0);
    total++; if (bz[0] !== 1'b1) begin bad++; $display("FAIL exact_busy got %b need 1", bz[0]); end
    for (int k = 0; k < 16; k++) begin
      drv(0, 1'b1, 8'(k + 1), 8'(k + 7), 16'((k + 1) * (k + 7)));
      tick;
    end
    drv(0, 1'b0, 8'd0, 8'd0, 16'd0);
    total++; if (ir[0] !== 1'b0) begin bad++; $display("FAIL exact_ready_drop got %b need 0", ir[0]); end
    total++; if (bz[0] !== 1'b1) begin bad++; $display("FAIL exact_drain_busy got %b need 1", bz[0]); end
    tick;
    total++; if (dn[0] !== 1'b0) begin bad++; $display("FAIL exact_done_early got %b need 0", dn[0]); end
    tick;
    total++; if (dn[0] !== 1'b1) begin bad++; $display("FAIL exact_done got %b need 1", dn[0]); end
    total++; if (bz[0] !== 1'b0) begin bad++; $display("FAIL exact_busy_end got %b need 0", bz[0]); end
    total++; if (sum[0] !== 36'd0) begin bad++; $display("FAIL exact_sum got %0d need 0", sum[0]); end
    total++; if (mx[0] !== 16'd0) begin bad++; $display("FAIL exact_max got %0d need 0", mx[0]); end
    total++; if (ec[0] !== 17'd0) begin bad++; $display("FAIL exact_err got %0d need 0", ec[0]); end
    total++; if (sc[0] !== 17'd16) begin bad++; $display("FAIL exact_smp got %0d need 16", sc[0]); end
  endtask

  task automatic test_vectors;
    logic [7:0]  tx [4] = '{8'd3, 8'd255, 8'd0, 8'd16};
    logic [7:0]  ty [4] = '{8'd5, 8'd255, 8'd7, 8'd16};
    logic [15:0] tz [4] = '{16'd14, 16'd65025, 16'd1, 16'd200};
    int          es [6] = '{0, 0, 1, 1, 2, 58};
    pulse_start(1);
    for (int e = 0; e < 6; e++) begin
      if (e < 4) drv(1, 1'b1, tx[e], ty[e], tz[e]);
      else       drv(1, 1'b0, 8'd0, 8'd0, 16'd0);
      tick;
      total++; if (sum[1] !== 36'(es[e])) begin bad++; $display("FAIL vec_sum_edge%0d got %0d need %0d", e + 1, sum[1], es[e]); end
      total++; if (dn[1] !== (e == 5)) begin bad++; $display("FAIL vec_done_edge%0d got %b need %b", e + 1, dn[1], (e == 5)); end
    end
    total++; if (mx[1] !== 16'd56) begin bad++; $display("FAIL vec_max got %0d need 56", mx[1]); end
    total++; if (ec[1] !== 17'd3) begin bad++; $display("FAIL vec_err got %0d need 3", ec[1]); end
    total++; if (sc[1] !== 17'd4) begin bad++; $display("FAIL vec_smp got %0d need 4", sc[1]); end
`ifdef APPROX_ERR_BIAS_EN
    total++; if (eb[1] !== -37'sd56) begin bad++; $display("FAIL vec_bias got %0d need -56", eb[1]); end
`endif
  endtask

  task automatic test_gaps;
    logic [19:0] pat = 20'b1011_0011_1010_1111_1111;
    int exp_n = 0;
    pulse_start(2);
    for (int c = 0; c < 20; c++) begin
      drv(2, pat[19-c], 8'(exp_n), 8'd2, 16'(exp_n * 2 + exp_n % 2));
      total++; if (ir[2] !== (exp_n < 8)) begin bad++; $display("FAIL gap_ready_c%0d got %b need %b", c, ir[2], (exp_n < 8)); end
      if (pat[19-c] && exp_n < 8) exp_n++;
      tick;
    end
    drv(2, 1'b0, 8'd0, 8'd0, 16'd0);
    total++; if (dn[2] !== 1'b1) begin bad++; $display("FAIL gap_done got %b need 1", dn[2]); end
    total++; if (sc[2] !== 17'd8) begin bad++; $display("FAIL gap_smp got %0d need 8", sc[2]); end
    total++; if (ec[2] !== 17'd4) begin bad++; $display("FAIL gap_err got %0d need 4", ec[2]); end
    total++; if (sum[2] !== 36'd4) begin bad++; $display("FAIL gap_sum got %0d need 4", sum[2]); end
    total++; if (mx[2] !== 16'd1) begin bad++; $display("FAIL gap_max got %0d need 1", mx[2]); end
  endtask

  task automatic test_start_control;
    pulse_start(1);
    total++; if (sum[1] !== 36'd0) begin bad++; $display("FAIL restart_sum got %0d need 0", sum[1]); end
    total++; if (mx[1] !== 16'd0) begin bad++; $display("FAIL restart_max got %0d need 0", mx[1]); end
    total++; if (ec[1] !== 17'd0) begin bad++; $display("FAIL restart_err got %0d need 0", ec[1]); end
    total++; if (sc[1] !== 17'd0) begin bad++; $display("FAIL restart_smp got %0d need 0", sc[1]); end
    total++; if (bz[1] !== 1'b1) begin bad++; $display("FAIL restart_busy got %b need 1", bz[1]); end
    total++; if (dn[1] !== 1'b0) begin bad++; $display("FAIL restart_done got %b need 0", dn[1]); end
`ifdef APPROX_ERR_BIAS_EN
    total++; if (eb[1] !== 37'sd0) begin bad++; $display("FAIL restart_bias got %0d need 0", eb[1]); end
`endif
    drv(1, 1'b1, 8'd2, 8'd3, 16'd6);  tick;
    drv(1, 1'b1, 8'd4, 8'd4, 16'd17); tick;
    drv(1, 1'b1, 8'd5, 8'd5, 16'd25);
    st[1] = 1'b1;
    tick;
    st[1] = 1'b0;
    total++; if (sc[1] !== 17'd3) begin bad++; $display("FAIL ignore_start_smp got %0d need 3", sc[1]); end
    total++; if (bz[1] !== 1'b1) begin bad++; $display("FAIL ignore_start_busy got %b need 1", bz[1]); end
    drv(1, 1'b1, 8'd1, 8'd1, 16'd0); tick;
    drv(1, 1'b0, 8'd0, 8'd0, 16'd0);
    tick;
    tick;
    total++; if (dn[1] !== 1'b1) begin bad++; $display("FAIL ignore_done got %b need 1", dn[1]); end
    total++; if (sc[1] !== 17'd4) begin bad++; $display("FAIL ignore_smp got %0d need 4", sc[1]); end
    total++; if (sum[1] !== 36'd2) begin bad++; $display("FAIL ignore_sum got %0d need 2", sum[1]); end
    total++; if (ec[1] !== 17'd2) begin bad++; $display("FAIL ignore_err got %0d need 2", ec[1]); end
  endtask

  task automatic test_saturate;
    pulse_start(3);
    for (int k = 0; k < 4; k++) begin
      drv(3, 1'b1, 8'd255, 8'd255, 16'd0);
      tick;
    end
    drv(3, 1'b0, 8'd0, 8'd0, 16'd0);
    wait_done(3, 10);
    total++; if (sum_s !== 16'hFFFF) begin bad++; $display("FAIL sat_sum got %0d need 65535", sum_s); end
    total++; if (mx[3] !== 16'd65025) begin bad++; $display("FAIL sat_max got %0d need 65025", mx[3]); end
    total++; if (ec[3] !== 17'd4) begin bad++; $display("FAIL sat_err got %0d need 4", ec[3]); end
`ifdef APPROX_ERR_BIAS_EN
    total++; if (eb_s !== -17'sd65536) begin bad++; $display("FAIL sat_bias got %0d need -65536", eb_s); end
`endif
  endtask

  task automatic test_reset_midrun;
    pulse_start(0);
    for (int k = 0; k < 5; k++) begin
      drv(0, 1'b1, 8'(k + 2), 8'd9, 16'((k + 2) * 9 + 3));
      tick;
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bz[0] !== 1'b0) begin bad++; $display("FAIL midrst_busy got %b need 0", bz[0]); end
    total++; if (ir[0] !== 1'b0) begin bad++; $display("FAIL midrst_ready got %b need 0", ir[0]); end
    total++; if (dn[0] !== 1'b0) begin bad++; $display("FAIL midrst_done got %b need 0", dn[0]); end
    total++; if (sc[0] !== 17'd0) begin bad++; $display("FAIL midrst_smp got %0d need 0", sc[0]); end
    total++; if (sum[0] !== 36'd0) begin bad++; $display("FAIL midrst_sum got %0d need 0", sum[0]); end
    total++; if (ec[0] !== 17'd0) begin bad++; $display("FAIL midrst_err got %0d need 0", ec[0]); end
    drv(0, 1'b0, 8'd0, 8'd0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    total++; if (bz[0] !== 1'b0) begin bad++; $display("FAIL midrst_idle got busy=%b need 0", bz[0]); end
    pulse_start(0);
    total++; if (sc[0] !== 17'd0) begin bad++; $display("FAIL rerun_smp0 got %0d need 0", sc[0]); end
    for (int k = 0; k < 16; k++) begin
      drv(0, 1'b1, 8'(k + 1), 8'd3, 16'((k + 1) * 3 + 2));
      tick;
    end
    drv(0, 1'b0, 8'd0, 8'd0, 16'd0);
    wait_done(0, 6);
    total++; if (sum[0] !== 36'd32) begin bad++; $display("FAIL rerun_sum got %0d need 32", sum[0]); end
    total++; if (mx[0] !== 16'd2) begin bad++; $display("FAIL rerun_max got %0d need 2", mx[0]); end
    total++; if (ec[0] !== 17'd16) begin bad++; $display("FAIL rerun_err got %0d need 16", ec[0]); end
    total++; if (sc[0] !== 17'd16) begin bad++; $display("FAIL rerun_smp got %0d need 16", sc[0]); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      st[i] = 1'b0;
      drv(i, 1'b0, 8'd0, 8'd0, 16'd0);
    end
    #12;
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    test_exact;
    test_vectors;
    test_gaps;
    test_start_control;
    test_saturate;
    test_reset_midrun;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
